axi_wr_arbiter: RTL and testbench

Shares one AXI4 master write port between `NUM_MASTER` write requesters, typically several write-DMA engines feeding one DDR/AXI slave. Arbitration is round-robin at burst granularity. A grant is held from the AW handshake through the B response, so only one burst is outstanding at a time. AXI read channels are not touched by this block.

---
 rtl/axi_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/axi_wr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 write-path constants and the write-arbiter state type.
package axi_pkg;

   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_STRB_W = AXI_DATA_W / 8;
   localparam int AXI_LEN_W  = 8;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_ARB,
      ST_ADDR,
      ST_DATA,
      ST_RESP
   } wr_arb_st_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_arbiter
   import axi_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   int unsigned      cand;
   logic [IDX_W-1:0] cand_idx;
   logic             found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned off = 1; off <= N; off++) begin
         cand = 32'(last_grant) + off;
         if (cand >= 32'(N)) begin
            cand = cand - 32'(N);
         end
         cand_idx = cand[IDX_W-1:0];
         if (!found && req[cand_idx]) begin
            found           = 1'b1;
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
         end
      end
   end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one AXI4 write port among NUM_MASTER requesters, one burst at a time,
// round-robin at burst granularity; the grant is held from AW through B.
module axi_wr_arbiter
   import axi_pkg::*;
#(
   parameter int NUM_MASTER = 2,
   parameter int ID_WIDTH   = 2
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_MASTER-1:0][AXI_ADDR_W-1:0] S_WR_ADDR,
   input  logic [NUM_MASTER-1:0][AXI_LEN_W-1:0]  S_WR_ADDR_LEN,
   input  logic [NUM_MASTER-1:0][1:0]            S_WR_ADDR_BURST,
   input  logic [NUM_MASTER-1:0]                 S_WR_ADDR_VALID,
   output logic [NUM_MASTER-1:0]                 S_WR_ADDR_READY,
   input  logic [NUM_MASTER-1:0][AXI_DATA_W-1:0] S_WR_DATA,
   input  logic [NUM_MASTER-1:0][AXI_STRB_W-1:0] S_WR_STRB,
   input  logic [NUM_MASTER-1:0]                 S_WR_DATA_LAST,
   input  logic [NUM_MASTER-1:0]                 S_WR_DATA_VALID,
   output logic [NUM_MASTER-1:0]                 S_WR_DATA_READY,
   output logic [NUM_MASTER-1:0][1:0]            S_WR_BACK_RESP,
   output logic [NUM_MASTER-1:0]                 S_WR_BACK_VALID,
   input  logic [NUM_MASTER-1:0]                 S_WR_BACK_READY,
   output logic [ID_WIDTH-1:0]                   MASTER_WR_ADDR_ID,
   output logic [AXI_ADDR_W-1:0]                 MASTER_WR_ADDR,
   output logic [AXI_LEN_W-1:0]                  MASTER_WR_ADDR_LEN,
   output logic [1:0]                            MASTER_WR_ADDR_BURST,
   output logic                                  MASTER_WR_ADDR_VALID,
   input  logic                                  MASTER_WR_ADDR_READY,
   output logic [AXI_DATA_W-1:0]                 MASTER_WR_DATA,
   output logic [AXI_STRB_W-1:0]                 MASTER_WR_STRB,
   output logic                                  MASTER_WR_DATA_LAST,
   output logic                                  MASTER_WR_DATA_VALID,
   input  logic                                  MASTER_WR_DATA_READY,
   input  logic [ID_WIDTH-1:0]                   MASTER_WR_BACK_ID,
   input  logic [1:0]                            MASTER_WR_BACK_RESP,
   input  logic                                  MASTER_WR_BACK_VALID,
   output logic                                  MASTER_WR_BACK_READY,
   output logic [$clog2(NUM_MASTER)-1:0]         grant_idx,
   output logic                                  busy,
   output logic                                  last_err
);

   localparam int IDX_W = $clog2(NUM_MASTER);

   wr_arb_st_t            state_q, state_d;
   logic [IDX_W-1:0]      grant_q, grant_d;
   logic [IDX_W-1:0]      last_grant_q, last_grant_d;
   logic [AXI_LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic                  last_err_q, last_err_d;
   logic [NUM_MASTER-1:0] arb_gnt;
   logic [IDX_W-1:0]      arb_idx;
   logic [NUM_MASTER-1:0] gnt_oh;
   logic                  beat_last;

   rr_arbiter #(
      .N     (NUM_MASTER),
      .IDX_W (IDX_W)
   ) u_rr (
      .req        (S_WR_ADDR_VALID),
      .last_grant (last_grant_q),
      .grant      (arb_gnt),
      .grant_idx  (arb_idx)
   );

   assign gnt_oh    = NUM_MASTER'(1) << grant_q;
   assign beat_last = (beat_cnt_q == '0);
   assign grant_idx = grant_q;
   assign busy      = (state_q != ST_ARB);
   assign last_err  = last_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_ARB;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(NUM_MASTER - 1);
         beat_cnt_q   <= '0;
         last_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         last_err_q   <= last_err_d;
      end
   end

   // All master-side and requester-side outputs are zero outside the phase that owns them.
   always_comb begin
      state_d              = state_q;
      grant_d              = grant_q;
      last_grant_d         = last_grant_q;
      beat_cnt_d           = beat_cnt_q;
      last_err_d           = last_err_q;
      S_WR_ADDR_READY      = '0;
      S_WR_DATA_READY      = '0;
      S_WR_BACK_RESP       = '0;
      S_WR_BACK_VALID      = '0;
      MASTER_WR_ADDR_ID    = '0;
      MASTER_WR_ADDR       = '0;
      MASTER_WR_ADDR_LEN   = '0;
      MASTER_WR_ADDR_BURST = '0;
      MASTER_WR_ADDR_VALID = 1'b0;
      MASTER_WR_DATA       = '0;
      MASTER_WR_STRB       = '0;
      MASTER_WR_DATA_LAST  = 1'b0;
      MASTER_WR_DATA_VALID = 1'b0;
      MASTER_WR_BACK_READY = 1'b0;
      unique case (state_q)
         ST_ARB: begin
            if (|arb_gnt) begin
               grant_d = arb_idx;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            MASTER_WR_ADDR_ID    = ID_WIDTH'(grant_q);
            MASTER_WR_ADDR       = S_WR_ADDR[grant_q];
            MASTER_WR_ADDR_LEN   = S_WR_ADDR_LEN[grant_q];
            MASTER_WR_ADDR_BURST = S_WR_ADDR_BURST[grant_q];
            MASTER_WR_ADDR_VALID = S_WR_ADDR_VALID[grant_q];
            S_WR_ADDR_READY      = MASTER_WR_ADDR_READY ? gnt_oh : '0;
            if (S_WR_ADDR_VALID[grant_q] && MASTER_WR_ADDR_READY) begin
               beat_cnt_d = S_WR_ADDR_LEN[grant_q];
               state_d    = ST_DATA;
            end
         end
         ST_DATA: begin
            MASTER_WR_DATA       = S_WR_DATA[grant_q];
            MASTER_WR_STRB       = S_WR_STRB[grant_q];
            MASTER_WR_DATA_LAST  = beat_last;
            MASTER_WR_DATA_VALID = S_WR_DATA_VALID[grant_q];
            S_WR_DATA_READY      = MASTER_WR_DATA_READY ? gnt_oh : '0;
            if (S_WR_DATA_VALID[grant_q] && MASTER_WR_DATA_READY) begin
               // The burst length is trusted over the requester's LAST flag.
               if (S_WR_DATA_LAST[grant_q] != beat_last) begin
                  last_err_d = 1'b1;
               end
               if (beat_last) begin
                  state_d = ST_RESP;
               end else begin
                  beat_cnt_d = beat_cnt_q - 1'b1;
               end
            end
         end
         ST_RESP: begin
            MASTER_WR_BACK_READY    = S_WR_BACK_READY[grant_q];
            S_WR_BACK_VALID         = MASTER_WR_BACK_VALID ? gnt_oh : '0;
            S_WR_BACK_RESP[grant_q] = MASTER_WR_BACK_RESP;
            if (MASTER_WR_BACK_VALID && S_WR_BACK_READY[grant_q]) begin
               if (MASTER_WR_BACK_ID != ID_WIDTH'(grant_q)) begin
                  last_err_d = 1'b1;
               end
               last_grant_d = grant_q;
               state_d      = ST_ARB;
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench: requesters and slave are emulated per cycle; observed
// grants, beats and responses are checked against a round-robin queue model.
module tb_axi_wr_arbiter;
   import axi_pkg::*;

   localparam int N  = 2;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0][31:0] s_addr;
   logic [N-1:0][7:0]  s_len;
   logic [N-1:0][1:0]  s_burst;
   logic [N-1:0]       s_aw_valid, s_aw_ready;
   logic [N-1:0][31:0] s_wdata;
   logic [N-1:0][3:0]  s_strb;
   logic [N-1:0]       s_wlast, s_wvalid, s_wready;
   logic [N-1:0][1:0]  s_bresp;
   logic [N-1:0]       s_bvalid, s_bready;
   logic [IW-1:0]      m_awid, m_bid;
   logic [31:0]        m_awaddr, m_wdata;
   logic [7:0]         m_awlen;
   logic [1:0]         m_awburst, m_bresp;
   logic [3:0]         m_wstrb;
   logic               m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
   logic               m_bvalid, m_bready;
   logic [0:0]         grant_idx;
   logic               busy, last_err;

   always #5 clk = ~clk;

   axi_wr_arbiter #(.NUM_MASTER(N), .ID_WIDTH(IW)) dut (
      .clk(clk), .rst(rst),
      .S_WR_ADDR(s_addr), .S_WR_ADDR_LEN(s_len), .S_WR_ADDR_BURST(s_burst),
      .S_WR_ADDR_VALID(s_aw_valid), .S_WR_ADDR_READY(s_aw_ready),
      .S_WR_DATA(s_wdata), .S_WR_STRB(s_strb), .S_WR_DATA_LAST(s_wlast),
      .S_WR_DATA_VALID(s_wvalid), .S_WR_DATA_READY(s_wready),
      .S_WR_BACK_RESP(s_bresp), .S_WR_BACK_VALID(s_bvalid), .S_WR_BACK_READY(s_bready),
      .MASTER_WR_ADDR_ID(m_awid), .MASTER_WR_ADDR(m_awaddr), .MASTER_WR_ADDR_LEN(m_awlen),
      .MASTER_WR_ADDR_BURST(m_awburst), .MASTER_WR_ADDR_VALID(m_awvalid),
      .MASTER_WR_ADDR_READY(m_awready),
      .MASTER_WR_DATA(m_wdata), .MASTER_WR_STRB(m_wstrb), .MASTER_WR_DATA_LAST(m_wlast),
      .MASTER_WR_DATA_VALID(m_wvalid), .MASTER_WR_DATA_READY(m_wready),
      .MASTER_WR_BACK_ID(m_bid), .MASTER_WR_BACK_RESP(m_bresp),
      .MASTER_WR_BACK_VALID(m_bvalid), .MASTER_WR_BACK_READY(m_bready),
      .grant_idx(grant_idx), .busy(busy), .last_err(last_err)
   );

   int vectors = 0;
   int miscompares = 0;

   // requester / slave emulation state
   int         pend[N];
   logic [7:0] mlen[N];
   logic [31:0] mbase[N];
   int         err_beat[N];
   bit         inflight[N], w_act[N], wait_b[N];
   int         w_beat[N];
   bit         aw_rand, force_id;
   int         w_mode;
   logic [1:0] sl_resp;
   logic [IW-1:0] forced_id;
   int         model_last;
   int         exp_order[$];

   // observations
   int obs_grant[$], obs_id[$], obs_addr[$], obs_bm[$], obs_bresp[$];
   int obs_busy_b[$], obs_beats[$], obs_lastpos[$], obs_lastcnt[$];
   int pt_errs, idle_errs, ovl_errs;
   bit timeout;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      s_addr = '0; s_len = '0; s_burst = '0; s_aw_valid = '0;
      s_wdata = '0; s_strb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '1;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0; m_bid = '0;
   endtask

   task automatic clear_model();
      for (int m = 0; m < N; m++) begin
         pend[m] = 0; inflight[m] = 0; w_act[m] = 0; wait_b[m] = 0;
         w_beat[m] = 0; err_beat[m] = -1; mlen[m] = '0; mbase[m] = 32'h1000 * (m + 1);
      end
      aw_rand = 0; w_mode = 0; force_id = 0; forced_id = '0; sl_resp = RESP_OKAY;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      clear_model();
      model_last = N - 1;
   endtask

   // Round-robin at burst level: next pending requester after the previous grantee.
   function automatic void predict();
      int pp[N];
      int total = 0;
      exp_order.delete();
      for (int m = 0; m < N; m++) begin pp[m] = pend[m]; total += pend[m]; end
      while (total > 0) begin
         for (int off = 1; off <= N; off++) begin
            int c = (model_last + off) % N;
            if (pp[c] > 0) begin
               exp_order.push_back(c); pp[c]--; total--; model_last = c;
               break;
            end
         end
      end
   endfunction

   task automatic run_engine(input int budget);
      int g, a, bm, sl_beats, sl_len, lpos, lcnt;
      bit done, chk_busy, b_next, sl_busy, sl_b, tog;
      logic [IW-1:0] sl_bid;
      obs_grant.delete(); obs_id.delete(); obs_addr.delete(); obs_bm.delete();
      obs_bresp.delete(); obs_busy_b.delete(); obs_beats.delete();
      obs_lastpos.delete(); obs_lastcnt.delete();
      pt_errs = 0; idle_errs = 0; ovl_errs = 0; timeout = 1;
      chk_busy = 0; b_next = 0; sl_busy = 0; sl_b = 0; tog = 0;
      sl_beats = 0; sl_len = 0; lpos = -1; lcnt = 0; sl_bid = '0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         for (int m = 0; m < N; m++) begin
            s_aw_valid[m] = (pend[m] > 0) && !inflight[m];
            s_addr[m] = mbase[m]; s_len[m] = mlen[m]; s_burst[m] = BURST_INCR;
            s_wvalid[m] = w_act[m]; s_wdata[m] = $urandom; s_strb[m] = 4'($urandom);
            s_wlast[m] = w_act[m] && ((w_beat[m] == int'(mlen[m])) != (w_beat[m] == err_beat[m]));
         end
         m_awready = aw_rand ? 1'($urandom) : 1'b1;
         if (w_mode == 0) m_wready = 1'b1;
         else if (w_mode == 1) begin tog = !tog; m_wready = tog; end
         else m_wready = 1'($urandom);
         m_bvalid = sl_b; m_bresp = sl_b ? sl_resp : '0; m_bid = sl_b ? sl_bid : '0;
         #1;
         if (chk_busy) begin obs_busy_b.push_back(int'(busy)); chk_busy = 0; end
         done = 1;
         for (int m = 0; m < N; m++) if (pend[m] > 0 || inflight[m]) done = 0;
         if (done) begin timeout = 0; break; end
         for (int m = 0; m < N; m++) begin
            if (s_wready[m] && !w_act[m]) idle_errs++;
            if (s_bvalid[m] && !wait_b[m]) idle_errs++;
            if (s_aw_ready[m] && !s_aw_valid[m]) idle_errs++;
         end
         if (m_awvalid && m_awready) begin
            g = -1;
            for (int m = 0; m < N; m++) if (s_aw_ready[m]) g = (g == -1) ? m : -2;
            obs_grant.push_back(g); obs_id.push_back(int'(m_awid)); obs_addr.push_back(int'(m_awaddr));
            if (sl_busy || sl_b) ovl_errs++;
            if (g >= 0) begin
               if (m_awaddr !== s_addr[g] || m_awlen !== s_len[g] || m_awburst !== s_burst[g]) pt_errs++;
               inflight[g] = 1; w_act[g] = 1; w_beat[g] = 0;
            end
            sl_busy = 1; sl_len = int'(m_awlen); sl_beats = 0; lpos = -1; lcnt = 0;
            sl_bid = force_id ? forced_id : m_awid;
         end
         if (m_wvalid && m_wready) begin
            a = -1;
            for (int m = 0; m < N; m++) if (w_act[m] && s_wready[m]) a = m;
            if (a < 0 || !sl_busy) pt_errs++;
            else begin
               if (m_wdata !== s_wdata[a] || m_wstrb !== s_strb[a]) pt_errs++;
               if (m_wlast) begin lcnt++; if (lpos < 0) lpos = sl_beats; end
               sl_beats++;
               w_beat[a]++;
               if (w_beat[a] > int'(mlen[a])) begin w_act[a] = 0; wait_b[a] = 1; end
               if (sl_beats == sl_len + 1) begin
                  sl_busy = 0; b_next = 1;
                  obs_beats.push_back(sl_beats); obs_lastpos.push_back(lpos); obs_lastcnt.push_back(lcnt);
               end
            end
         end
         if (m_bvalid && m_bready) begin
            bm = -1;
            for (int m = 0; m < N; m++) if (s_bvalid[m]) bm = m;
            obs_bm.push_back(bm);
            obs_bresp.push_back(bm >= 0 ? int'(s_bresp[bm]) : -1);
            if (bm >= 0) begin wait_b[bm] = 0; inflight[bm] = 0; pend[bm]--; end
            sl_b = 0; chk_busy = 1;
         end
         if (b_next) begin sl_b = 1; b_next = 0; end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      do_reset();
      m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bid = 2'd1;
      #1;
      vectors++;
      if ({busy, last_err, grant_idx} !== 3'b000) begin
         miscompares++; $display("FAIL reset_status: busy/last_err/grant=%b required 000", {busy, last_err, grant_idx});
      end
      vectors++;
      if ({m_awvalid, m_wvalid, m_wlast, m_bready, s_aw_ready, s_wready, s_bvalid} !== '0) begin
         miscompares++; $display("FAIL reset_handshakes: got %b required 0",
            {m_awvalid, m_wvalid, m_wlast, m_bready, s_aw_ready, s_wready, s_bvalid});
      end
      vectors++;
      if (m_awaddr !== 32'd0 || m_awid !== '0 || m_wdata !== 32'd0 || m_awlen !== 8'd0) begin
         miscompares++; $display("FAIL reset_data: addr=%h id=%0d wdata=%h len=%0d required 0", m_awaddr, m_awid, m_wdata, m_awlen);
      end
      // arbitration latency and AW hold without rearbitration
      m_bvalid = 1'b0; m_awready = 1'b0;
      s_aw_valid[0] = 1'b1; s_addr[0] = 32'hABCD_0000; s_len[0] = 8'd2;
      #1;
      vectors++;
      if (m_awvalid !== 1'b0) begin miscompares++; $display("FAIL arb_cycle_awvalid: got %b required 0", m_awvalid); end
      @(posedge clk); #1;
      vectors++;
      if (m_awvalid !== 1'b1 || m_awaddr !== 32'hABCD_0000 || busy !== 1'b1) begin
         miscompares++; $display("FAIL addr_latency: valid=%b addr=%h busy=%b required 1 abcd0000 1", m_awvalid, m_awaddr, busy);
      end
      s_aw_valid[0] = 1'b0; s_aw_valid[1] = 1'b1; m_awready = 1'b1;
      @(posedge clk); #1; @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b1 || grant_idx !== 1'b0 || m_awvalid !== 1'b0 || s_aw_ready !== 2'b01) begin
         miscompares++; $display("FAIL addr_hold: busy=%b grant=%0d awvalid=%b s_ready=%b required 1 0 0 01",
            busy, grant_idx, m_awvalid, s_aw_ready);
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      pend[0] = 1; mlen[0] = 8'd3; mbase[0] = 32'h100;
      predict();
      run_engine(200);
      vectors++;
      if (timeout || obs_grant.size() != 1 || obs_beats.size() != 1 || obs_busy_b.size() != 1) begin
         miscompares++; $display("FAIL single_complete: timeout=%0d grants=%0d bursts=%0d required 0 1 1", timeout, obs_grant.size(), obs_beats.size());
      end else begin
         vectors++;
         if (obs_grant[0] != 0 || obs_id[0] != 0 || obs_addr[0] != 32'h100) begin
            miscompares++; $display("FAIL single_aw: grant=%0d id=%0d addr=%h required 0 0 100", obs_grant[0], obs_id[0], obs_addr[0]);
         end
         vectors++;
         if (obs_beats[0] != 4 || obs_lastpos[0] != 3 || obs_lastcnt[0] != 1) begin
            miscompares++; $display("FAIL single_beats: beats=%0d lastpos=%0d lastcnt=%0d required 4 3 1", obs_beats[0], obs_lastpos[0], obs_lastcnt[0]);
         end
         vectors++;
         if (obs_bm[0] != 0 || obs_bresp[0] != int'(RESP_OKAY) || obs_busy_b[0] != 0) begin
            miscompares++; $display("FAIL single_b: master=%0d resp=%0d busy_after=%0d required 0 0 0", obs_bm[0], obs_bresp[0], obs_busy_b[0]);
         end
      end
      vectors++;
      if (pt_errs + idle_errs + ovl_errs != 0 || last_err !== 1'b0) begin
         miscompares++; $display("FAIL single_clean: pt=%0d idle=%0d ovl=%0d last_err=%b required 0 0 0 0", pt_errs, idle_errs, ovl_errs, last_err);
      end
   endtask

   task automatic test_round_robin();
      int bursts;
      do_reset();
      for (int iter = 0; iter < 4; iter++) begin
         if (iter == 0) begin
            pend[0] = 2; pend[1] = 2; mlen[0] = 8'd0; mlen[1] = 8'd0;
         end else begin
            aw_rand = 1; w_mode = 2;
            for (int m = 0; m < N; m++) begin pend[m] = $urandom_range(1, 3); mlen[m] = 8'($urandom_range(0, 15)); end
         end
         predict();
         run_engine(3000);
         bursts = exp_order.size();
         vectors++;
         if (timeout || obs_grant.size() != bursts || obs_beats.size() != bursts || obs_bm.size() != bursts) begin
            miscompares++; $display("FAIL rr_complete[%0d]: timeout=%0d grants=%0d required %0d", iter, timeout, obs_grant.size(), bursts);
            continue;
         end
         for (int k = 0; k < bursts; k++) begin
            int e = exp_order[k];
            vectors++;
            if (obs_grant[k] != e || obs_id[k] != e || obs_bm[k] != e) begin
               miscompares++; $display("FAIL rr_order[%0d.%0d]: grant=%0d id=%0d bmaster=%0d required %0d", iter, k, obs_grant[k], obs_id[k], obs_bm[k], e);
            end
            vectors++;
            if (obs_beats[k] != int'(mlen[e]) + 1 || obs_lastpos[k] != int'(mlen[e]) || obs_lastcnt[k] != 1) begin
               miscompares++; $display("FAIL rr_beats[%0d.%0d]: beats=%0d lastpos=%0d required %0d %0d", iter, k, obs_beats[k], obs_lastpos[k], int'(mlen[e]) + 1, mlen[e]);
            end
         end
         vectors++;
         if (pt_errs + idle_errs + ovl_errs != 0 || int'(grant_idx) != model_last) begin
            miscompares++; $display("FAIL rr_clean[%0d]: pt=%0d idle=%0d ovl=%0d grant_idx=%0d required 0 0 0 %0d", iter, pt_errs, idle_errs, ovl_errs, grant_idx, model_last);
         end
      end
   endtask

   task automatic test_long_burst();
      do_reset();
      pend[0] = 1; mlen[0] = 8'd1;
      predict(); run_engine(100);
      pend[0] = 1; mlen[0] = 8'($urandom_range(0, 7)); pend[1] = 1; mlen[1] = 8'd255; w_mode = 1;
      predict(); run_engine(2000);
      vectors++;
      if (timeout || obs_grant.size() != 2 || obs_beats.size() != 2) begin
         miscompares++; $display("FAIL long_complete: timeout=%0d grants=%0d bursts=%0d required 0 2 2", timeout, obs_grant.size(), obs_beats.size());
      end else begin
         vectors++;
         if (obs_grant[0] != 1 || obs_grant[1] != 0 || obs_id[0] != 1) begin
            miscompares++; $display("FAIL long_order: first=%0d second=%0d id=%0d required 1 0 1", obs_grant[0], obs_grant[1], obs_id[0]);
         end
         vectors++;
         if (obs_beats[0] != 256 || obs_lastpos[0] != 255 || obs_lastcnt[0] != 1) begin
            miscompares++; $display("FAIL long_beats: beats=%0d lastpos=%0d lastcnt=%0d required 256 255 1", obs_beats[0], obs_lastpos[0], obs_lastcnt[0]);
         end
         vectors++;
         if (obs_beats[1] != int'(mlen[0]) + 1) begin
            miscompares++; $display("FAIL long_next_beats: beats=%0d required %0d", obs_beats[1], int'(mlen[0]) + 1);
         end
      end
      vectors++;
      if (ovl_errs + pt_errs + idle_errs != 0) begin
         miscompares++; $display("FAIL long_overlap: ovl=%0d pt=%0d idle=%0d required 0", ovl_errs, pt_errs, idle_errs);
      end
   endtask

   task automatic test_last_err();
      for (int iter = 0; iter < 2; iter++) begin
         do_reset();
         pend[0] = 1;
         if (iter == 0) begin mlen[0] = 8'd3; err_beat[0] = 1; end
         else begin mlen[0] = 8'($urandom_range(1, 6)); err_beat[0] = $urandom_range(0, int'(mlen[0]) - 1); end
         predict(); run_engine(300);
         vectors++;
         if (timeout || obs_beats.size() != 1 || last_err !== 1'b1) begin
            miscompares++; $display("FAIL lasterr_set[%0d]: timeout=%0d last_err=%b required 0 1", iter, timeout, last_err);
         end else begin
            vectors++;
            if (obs_beats[0] != int'(mlen[0]) + 1 || obs_lastpos[0] != int'(mlen[0])) begin
               miscompares++; $display("FAIL lasterr_count[%0d]: beats=%0d lastpos=%0d required %0d %0d", iter, obs_beats[0], obs_lastpos[0], int'(mlen[0]) + 1, mlen[0]);
            end
         end
         pend[1] = 1; mlen[1] = 8'd2; err_beat[0] = -1;
         predict(); run_engine(300);
         vectors++;
         if (timeout || last_err !== 1'b1) begin
            miscompares++; $display("FAIL lasterr_sticky[%0d]: timeout=%0d last_err=%b required 0 1", iter, timeout, last_err);
         end
      end
      do_reset();
      vectors++;
      if (last_err !== 1'b0) begin miscompares++; $display("FAIL lasterr_clear: got %b required 0", last_err); end
   endtask

   task automatic test_reset_mid_burst();
      int beats = 0;
      bit aw_hs, hit = 0;
      do_reset();
      s_aw_valid[0] = 1'b1; s_len[0] = 8'd15; s_addr[0] = 32'h2000; s_burst[0] = BURST_INCR;
      m_awready = 1'b1; m_wready = 1'b1;
      for (int cyc = 0; cyc < 60 && !hit; cyc++) begin
         #1;
         aw_hs = m_awvalid && m_awready;
         if (m_wvalid && m_wready) beats++;
         @(posedge clk); #1;
         if (aw_hs) begin s_aw_valid[0] = 1'b0; s_wvalid[0] = 1'b1; end
         if (beats == 4) begin rst = 1'b1; hit = 1; end
      end
      vectors++;
      if (!hit) begin miscompares++; $display("FAIL midrst_reach: beats=%0d required 4", beats); end
      @(posedge clk); #1;
      rst = 1'b0; s_wvalid[0] = 1'b0; m_bvalid = 1'b1; m_bid = '0;
      #1;
      vectors++;
      if ({m_awvalid, m_wvalid, m_wlast, m_bready, s_aw_ready, s_wready, s_bvalid, busy, grant_idx} !== '0) begin
         miscompares++; $display("FAIL midrst_outputs: got %b required 0",
            {m_awvalid, m_wvalid, m_wlast, m_bready, s_aw_ready, s_wready, s_bvalid, busy, grant_idx});
      end
      idle_inputs(); clear_model(); model_last = N - 1;
      pend[1] = 1; mlen[1] = 8'($urandom_range(1, 20));
      predict(); run_engine(300);
      vectors++;
      if (timeout || obs_beats.size() != 1 || obs_grant.size() != 1) begin
         miscompares++; $display("FAIL midrst_fresh: timeout=%0d bursts=%0d required 0 1", timeout, obs_beats.size());
      end else begin
         vectors++;
         if (obs_grant[0] != 1 || obs_id[0] != 1 || obs_beats[0] != int'(mlen[1]) + 1 || obs_lastpos[0] != int'(mlen[1])) begin
            miscompares++; $display("FAIL midrst_burst: grant=%0d id=%0d beats=%0d lastpos=%0d required 1 1 %0d %0d",
               obs_grant[0], obs_id[0], obs_beats[0], obs_lastpos[0], int'(mlen[1]) + 1, mlen[1]);
         end
      end
   endtask

   task automatic test_slverr();
      do_reset();
      pend[0] = 1; mlen[0] = 8'($urandom_range(0, 9));
      sl_resp = RESP_SLVERR; force_id = 1; forced_id = 2'd1;
      predict(); run_engine(300);
      vectors++;
      if (timeout || obs_bm.size() != 1) begin
         miscompares++; $display("FAIL slverr_complete: timeout=%0d responses=%0d required 0 1", timeout, obs_bm.size());
      end else begin
         vectors++;
         if (obs_bm[0] != 0 || obs_bresp[0] != int'(RESP_SLVERR)) begin
            miscompares++; $display("FAIL slverr_route: master=%0d resp=%0d required 0 2", obs_bm[0], obs_bresp[0]);
         end
      end
      vectors++;
      if (last_err !== 1'b1) begin miscompares++; $display("FAIL slverr_idmismatch: last_err=%b required 1", last_err); end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      clear_model();
      test_reset();
      test_single();
      test_round_robin();
      test_long_burst();
      test_last_err();
      test_reset_mid_burst();
      test_slverr();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
